// File: rtl/min_sum_serial_cnu.sv
`default_nettype none
// ============================================================================
// Module   : min_sum_serial_cnu
// Purpose  : Streaming check-node min-finder for a layered min-sum LDPC
//            decoder. Accepts one sign-magnitude variable-to-check message per
//            cycle and returns exact min1, min2, min1 index, sign product and
//            row degree per row through a valid/ready output register.
// Options  : OFFSET_MS_EN - when defined, min1/min2 are reduced by OFFSET with
//            saturation at zero as they are loaded into the output register.
// Revision : 1.0 - initial release
// ============================================================================
module min_sum_serial_cnu #(
   parameter int MAG_W   = 5,
   parameter int DEG_MAX = 19,
   parameter int IDX_W   = 5,
   parameter int OFFSET  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic             in_sign,
   input  logic [MAG_W-1:0] in_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MAG_W-1:0] out_min1,
   output logic [MAG_W-1:0] out_min2,
   output logic [IDX_W-1:0] out_min1_idx,
   output logic             out_sign_prod,
   output logic [IDX_W:0]   out_deg,
   output logic             err_overflow
);

   localparam logic [0:0]       S_IDLE    = 1'b0;
   localparam logic [0:0]       S_ACC     = 1'b1;
   localparam logic [MAG_W-1:0] C_MAG_MAX = '1;
   localparam logic [IDX_W:0]   C_DEG_MAX = (IDX_W+1)'(DEG_MAX);
   localparam logic [IDX_W:0]   C_CNT_ONE = (IDX_W+1)'(1);

`ifdef OFFSET_MS_EN
   // Offset min-sum: beta subtracted from both minima at output load.
   localparam logic [MAG_W-1:0] C_BETA = MAG_W'(OFFSET);
`else
   // Plain min-sum: beta is zero, so the saturating subtract folds away.
   localparam logic [MAG_W-1:0] C_BETA = MAG_W'(OFFSET * 0);
`endif

   // Saturating subtract of beta; never wraps below zero.
   function automatic logic [MAG_W-1:0] f_apply_offset(input logic [MAG_W-1:0] v);
      return (v > C_BETA) ? (v - C_BETA) : '0;
   endfunction

   // FSM state
   logic [0:0]       state_q, state_d;

   // Row accumulators
   logic [MAG_W-1:0] min1_q, min1_d;
   logic [MAG_W-1:0] min2_q, min2_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             sign_q, sign_d;
   logic [IDX_W:0]   cnt_q, cnt_d;

   // Output register
   logic             out_valid_q, out_valid_d;
   logic [MAG_W-1:0] out_min1_q, out_min1_d;
   logic [MAG_W-1:0] out_min2_q, out_min2_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             out_sign_q, out_sign_d;
   logic [IDX_W:0]   out_deg_q, out_deg_d;
   logic             err_q, err_d;

   // Accumulator values after merging the current beat
   logic [MAG_W-1:0] w_min1;
   logic [MAG_W-1:0] w_min2;
   logic [IDX_W-1:0] w_idx;
   logic             w_sign;
   logic [IDX_W:0]   w_cnt;

   // Beat control
   logic             w_accept;
   logic             w_publish;
   logic             w_overflow;

   // Input may be taken whenever the output slot is free or draining this cycle.
   assign in_ready = !out_valid_q | out_ready;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: flush or a publishing beat ends the row.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else if (w_accept) begin
         state_d = w_publish ? S_IDLE : S_ACC;
      end
   end

   // FSM outputs: beat acceptance, publish and overflow decode.
   always_comb begin
      w_accept   = in_valid & in_ready & ~flush;
      w_publish  = w_accept & (in_last | (w_cnt == C_DEG_MAX));
      w_overflow = w_publish & ~in_last;
   end

   // Merge the incoming beat into the running minima; first beat seeds them.
   always_comb begin
      w_min1 = min1_q;
      w_min2 = min2_q;
      w_idx  = idx_q;
      w_sign = sign_q ^ in_sign;
      w_cnt  = cnt_q + C_CNT_ONE;
      if (state_q == S_IDLE) begin
         w_min1 = in_mag;
         w_min2 = C_MAG_MAX;
         w_idx  = '0;
         w_sign = in_sign;
         w_cnt  = C_CNT_ONE;
      end else if (in_mag < min1_q) begin
         // Strictly smaller only: on a tie the earlier index keeps min1.
         w_min2 = min1_q;
         w_min1 = in_mag;
         w_idx  = cnt_q[IDX_W-1:0];
      end else if (in_mag < min2_q) begin
         w_min2 = in_mag;
      end
   end

   // Accumulator next state: cleared at row end or flush, loaded on accepted beats.
   always_comb begin
      min1_d = min1_q;
      min2_d = min2_q;
      idx_d  = idx_q;
      sign_d = sign_q;
      cnt_d  = cnt_q;
      if (flush | w_publish) begin
         min1_d = '0;
         min2_d = '0;
         idx_d  = '0;
         sign_d = 1'b0;
         cnt_d  = '0;
      end else if (w_accept) begin
         min1_d = w_min1;
         min2_d = w_min2;
         idx_d  = w_idx;
         sign_d = w_sign;
         cnt_d  = w_cnt;
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min1_q <= '0;
         min2_q <= '0;
         idx_q  <= '0;
         sign_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         min1_q <= min1_d;
         min2_q <= min2_d;
         idx_q  <= idx_d;
         sign_q <= sign_d;
         cnt_q  <= cnt_d;
      end
   end

   // Output register next state: load on publish, hold under backpressure.
   always_comb begin
      out_min1_d  = out_min1_q;
      out_min2_d  = out_min2_q;
      out_idx_d   = out_idx_q;
      out_sign_d  = out_sign_q;
      out_deg_d   = out_deg_q;
      out_valid_d = w_publish | (out_valid_q & ~out_ready);
      err_d       = err_q | w_overflow;
      if (w_publish) begin
         out_min1_d = f_apply_offset(w_min1);
         out_min2_d = f_apply_offset(w_min2);
         out_idx_d  = w_idx;
         out_sign_d = w_sign;
         out_deg_d  = w_cnt;
      end
   end

   // Output registers; the overflow flag is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_min1_q  <= '0;
         out_min2_q  <= '0;
         out_idx_q   <= '0;
         out_sign_q  <= 1'b0;
         out_deg_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_min1_q  <= out_min1_d;
         out_min2_q  <= out_min2_d;
         out_idx_q   <= out_idx_d;
         out_sign_q  <= out_sign_d;
         out_deg_q   <= out_deg_d;
         err_q       <= err_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_min1      = out_min1_q;
   assign out_min2      = out_min2_q;
   assign out_min1_idx  = out_idx_q;
   assign out_sign_prod = out_sign_q;
   assign out_deg       = out_deg_q;
   assign err_overflow  = err_q;

endmodule
`default_nettype wire
